pipeline_control_unit: RTL and testbench

- Next-generation control for the five-stage pipelined MIPS core; replaces single-cycle decode.
- Decodes opcode/funct in ID and carries the control bundle through ID/EX, EX/MEM and MEM/WB registers.
- Detects data hazards (stall) and control hazards (flush), and drives PC/IF-ID write enables.
- Optionally generates EX-stage forwarding selects.

---
 rtl/pipeline_control_unit_if.sv | 59 +++++
 rtl/pipeline_control_unit.sv | 190 +++++++++++++++++++
 tb/tb_pipeline_control_unit.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_control_unit_if.sv
// pipeline_control_unit_if: control bundle between MIPS datapath (master) and pipeline control unit (slave); forward selects exist only with FORWARDING_EN
interface pipeline_control_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W = 3
);
  logic [5:0] id_op;
  logic [5:0] id_funct;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic [REG_ADDR_W-1:0] id_rd;
  logic ex_branch_taken;
  logic pc_write;
  logic ifid_write;
  logic ifid_flush;
  logic id_jump;
  logic id_illegal;
  logic [ALUOP_W-1:0] ex_alu_op;
  logic ex_alu_src;
  logic ex_shamt_sel;
  logic ex_reg_dst;
  logic ex_branch_eq;
  logic ex_branch_ne;
  logic [REG_ADDR_W-1:0] ex_rs;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic mem_mem_read;
  logic mem_mem_write;
  logic mem_reg_write;
  logic [REG_ADDR_W-1:0] mem_dst;
  logic wb_reg_write;
  logic wb_mem_to_reg;
  logic wb_link;
  logic [REG_ADDR_W-1:0] wb_dst;
`ifdef FORWARDING_EN
  logic [1:0] forward_a;
  logic [1:0] forward_b;
`endif

  modport master (
    output id_op, id_funct, id_rs, id_rt, id_rd, ex_branch_taken,
`ifdef FORWARDING_EN
    input forward_a, forward_b,
`endif
    input pc_write, ifid_write, ifid_flush, id_jump, id_illegal,
    input ex_alu_op, ex_alu_src, ex_shamt_sel, ex_reg_dst, ex_branch_eq, ex_branch_ne, ex_rs, ex_rt,
    input mem_mem_read, mem_mem_write, mem_reg_write, mem_dst,
    input wb_reg_write, wb_mem_to_reg, wb_link, wb_dst
  );

  modport slave (
    input id_op, id_funct, id_rs, id_rt, id_rd, ex_branch_taken,
`ifdef FORWARDING_EN
    output forward_a, forward_b,
`endif
    output pc_write, ifid_write, ifid_flush, id_jump, id_illegal,
    output ex_alu_op, ex_alu_src, ex_shamt_sel, ex_reg_dst, ex_branch_eq, ex_branch_ne, ex_rs, ex_rt,
    output mem_mem_read, mem_mem_write, mem_reg_write, mem_dst,
    output wb_reg_write, wb_mem_to_reg, wb_link, wb_dst
  );
endinterface

// File: rtl/pipeline_control_unit.sv
// pipeline_control_unit: five-stage MIPS decode, ID/EX-EX/MEM-MEM/WB control registers, stall/flush generation; FORWARDING_EN adds EX forward selects and limits stalls to load-use
module pipeline_control_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W = 3,
  parameter int LINK_REG = 31
) (
  input logic clk,
  input logic reset,
  pipeline_control_unit_if.slave bus
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI = 6'h0d;
  localparam logic [5:0] OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2b;

  typedef logic [REG_ADDR_W-1:0] RegIdx;

  typedef struct packed {
    logic [ALUOP_W-1:0] aluOp;
    logic aluSrc;
    logic shamtSel;
    logic regDst;
    logic branchEq;
    logic branchNe;
    logic memRead;
    logic memWrite;
    logic regWrite;
    logic memToReg;
    logic link;
    RegIdx rs;
    RegIdx rt;
    RegIdx dst;
  } ExBundle;

  typedef struct packed {
    logic memRead;
    logic memWrite;
    logic regWrite;
    logic memToReg;
    logic link;
    RegIdx dst;
  } MemBundle;

  typedef struct packed {
    logic regWrite;
    logic memToReg;
    logic link;
    RegIdx dst;
  } WbBundle;

  ExBundle dec;
  ExBundle ex;
  MemBundle mem;
  WbBundle wb;
  logic decJump;
  logic decIllegal;
  logic useRs;
  logic useRt;
  logic hazard;
  logic branchFlush;
  logic stall;
  logic jumpNow;

  // ID decode: opcode/funct to control bundle, destination and operand usage
  always_comb begin
    dec = '0;
    decJump = 1'b0;
    decIllegal = 1'b0;
    useRs = 1'b0;
    useRt = 1'b0;
    case (bus.id_op)
      OP_RTYPE: begin
        dec.aluOp = ALUOP_W'(3'b111);
        dec.regDst = 1'b1;
        dec.regWrite = 1'b1;
        dec.shamtSel = bus.id_funct == 6'h00 || bus.id_funct == 6'h02;
        dec.dst = bus.id_rd;
        useRs = !dec.shamtSel;
        useRt = 1'b1;
      end
      OP_ADDI, OP_ORI, OP_LUI: begin
        dec.aluOp = ALUOP_W'(bus.id_op == OP_ADDI ? 3'b100 : bus.id_op == OP_ORI ? 3'b101 : 3'b110);
        dec.aluSrc = 1'b1;
        dec.regWrite = 1'b1;
        dec.dst = bus.id_rt;
        useRs = bus.id_op != OP_LUI;
      end
      OP_LW: begin
        dec.aluOp = ALUOP_W'(3'b100);
        dec.aluSrc = 1'b1;
        dec.memRead = 1'b1;
        dec.memToReg = 1'b1;
        dec.regWrite = 1'b1;
        dec.dst = bus.id_rt;
        useRs = 1'b1;
      end
      OP_SW: begin
        dec.aluOp = ALUOP_W'(3'b100);
        dec.aluSrc = 1'b1;
        dec.memWrite = 1'b1;
        useRs = 1'b1;
        useRt = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec.branchEq = bus.id_op == OP_BEQ;
        dec.branchNe = bus.id_op == OP_BNE;
        useRs = 1'b1;
        useRt = 1'b1;
      end
      OP_J: decJump = 1'b1;
      OP_JAL: begin
        decJump = 1'b1;
        dec.regWrite = 1'b1;
        dec.link = 1'b1;
        dec.dst = RegIdx'(LINK_REG);
      end
      default: decIllegal = 1'b1;
    endcase
    dec.rs = decIllegal ? '0 : bus.id_rs;
    dec.rt = decIllegal ? '0 : bus.id_rt;
    dec.regWrite = dec.regWrite && dec.dst != '0;
  end

  // Hazard detection and priority: reset > branch flush > stall > jump
  always_comb begin
`ifdef FORWARDING_EN
    hazard = ex.memRead && ex.dst != '0 &&
             ((useRs && bus.id_rs == ex.dst) || (useRt && bus.id_rt == ex.dst));
`else
    hazard = (useRs && bus.id_rs != '0 &&
              ((ex.regWrite && bus.id_rs == ex.dst) || (mem.regWrite && bus.id_rs == mem.dst))) ||
             (useRt && bus.id_rt != '0 &&
              ((ex.regWrite && bus.id_rt == ex.dst) || (mem.regWrite && bus.id_rt == mem.dst)));
`endif
    branchFlush = !reset && bus.ex_branch_taken;
    stall = !reset && !branchFlush && hazard;
    jumpNow = !reset && !branchFlush && !stall && decJump;
  end

  // Pipeline registers: ID/EX takes decode or bubble, later stages always shift
  always_ff @(posedge clk) begin
    if (reset) begin
      ex <= '0;
      mem <= '0;
      wb <= '0;
    end else begin
      ex <= (stall || branchFlush) ? '0 : dec;
      mem <= '{ex.memRead, ex.memWrite, ex.regWrite, ex.memToReg, ex.link, ex.dst};
      wb <= '{mem.regWrite, mem.memToReg, mem.link, mem.dst};
    end
  end

  assign bus.pc_write = !stall;
  assign bus.ifid_write = !stall;
  assign bus.ifid_flush = branchFlush || jumpNow;
  assign bus.id_jump = jumpNow;
  assign bus.id_illegal = decIllegal;
  assign bus.ex_alu_op = ex.aluOp;
  assign bus.ex_alu_src = ex.aluSrc;
  assign bus.ex_shamt_sel = ex.shamtSel;
  assign bus.ex_reg_dst = ex.regDst;
  assign bus.ex_branch_eq = ex.branchEq;
  assign bus.ex_branch_ne = ex.branchNe;
  assign bus.ex_rs = ex.rs;
  assign bus.ex_rt = ex.rt;
  assign bus.mem_mem_read = mem.memRead;
  assign bus.mem_mem_write = mem.memWrite;
  assign bus.mem_reg_write = mem.regWrite;
  assign bus.mem_dst = mem.dst;
  assign bus.wb_reg_write = wb.regWrite;
  assign bus.wb_mem_to_reg = wb.memToReg;
  assign bus.wb_link = wb.link;
  assign bus.wb_dst = wb.dst;

`ifdef FORWARDING_EN
  // EX operand selects: EX/MEM result beats MEM/WB result
  always_comb begin
    bus.forward_a = (mem.regWrite && mem.dst != '0 && mem.dst == ex.rs) ? 2'b10 :
                    (wb.regWrite && wb.dst != '0 && wb.dst == ex.rs) ? 2'b01 : 2'b00;
    bus.forward_b = (mem.regWrite && mem.dst != '0 && mem.dst == ex.rt) ? 2'b10 :
                    (wb.regWrite && wb.dst != '0 && wb.dst == ex.rt) ? 2'b01 : 2'b00;
  end
`endif
endmodule

// File: tb/tb_pipeline_control_unit.sv
// tb_pipeline_control_unit: scoreboard bench for pipeline_control_unit decode, stalls, flushes and forwarding
module tb_pipeline_control_unit;
  typedef enum int {PCW, IFW, FLUSH, JUMP, ILL, ALUOP, ALUSRC, SHAMT, REGDST, BEQ, BNE, EXRS, EXRT,
                    MRD, MWR, MRW, MDST, WRW, WMTR, WLINK, WDST, FA, FB} sig_e;
  typedef struct {
    int cyc;
    sig_e sig;
    int val;
    string tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int nChecks = 0;
  int nFail = 0;
  exp_t sb[$];
  exp_t keep[$];

  pipeline_control_unit_if bus();
  pipeline_control_unit dut(.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int peek(sig_e s);
    case (s)
      PCW: return int'(bus.pc_write);
      IFW: return int'(bus.ifid_write);
      FLUSH: return int'(bus.ifid_flush);
      JUMP: return int'(bus.id_jump);
      ILL: return int'(bus.id_illegal);
      ALUOP: return int'(bus.ex_alu_op);
      ALUSRC: return int'(bus.ex_alu_src);
      SHAMT: return int'(bus.ex_shamt_sel);
      REGDST: return int'(bus.ex_reg_dst);
      BEQ: return int'(bus.ex_branch_eq);
      BNE: return int'(bus.ex_branch_ne);
      EXRS: return int'(bus.ex_rs);
      EXRT: return int'(bus.ex_rt);
      MRD: return int'(bus.mem_mem_read);
      MWR: return int'(bus.mem_mem_write);
      MRW: return int'(bus.mem_reg_write);
      MDST: return int'(bus.mem_dst);
      WRW: return int'(bus.wb_reg_write);
      WMTR: return int'(bus.wb_mem_to_reg);
      WLINK: return int'(bus.wb_link);
      WDST: return int'(bus.wb_dst);
`ifdef FORWARDING_EN
      FA: return int'(bus.forward_a);
      FB: return int'(bus.forward_b);
`endif
      default: return -1;
    endcase
  endfunction

  task automatic chk(input int d, input sig_e s, input int v, input string tag);
    sb.push_back('{cyc + d, s, v, tag});
  endtask

  task automatic issue(input logic [5:0] op, input logic [5:0] funct, input int rs, input int rt, input int rd);
    bus.id_op = op;
    bus.id_funct = funct;
    bus.id_rs = 5'(rs);
    bus.id_rt = 5'(rt);
    bus.id_rd = 5'(rd);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic nops(input int n);
    issue(6'h00, 6'h00, 0, 0, 0);
    repeat (n) tick();
  endtask

  always @(negedge clk) begin
    keep.delete();
    foreach (sb[i]) begin
      if (sb[i].cyc == cyc) begin
        nChecks++;
        if (peek(sb[i].sig) != sb[i].val) begin
          nFail++;
          $display("FAIL %s [%s] cycle %0d: got %0d, wanted %0d", sb[i].tag, sb[i].sig.name(), cyc, peek(sb[i].sig), sb[i].val);
        end
      end else if (sb[i].cyc < cyc) begin
        nChecks++;
        nFail++;
        $display("FAIL %s [%s] missed cycle %0d: got none, wanted %0d", sb[i].tag, sb[i].sig.name(), sb[i].cyc, sb[i].val);
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  end

  initial begin
    bus.ex_branch_taken = 1'b0;
    issue(6'h00, 6'h00, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    chk(0, PCW, 1, "reset");
    chk(0, IFW, 1, "reset");
    chk(0, FLUSH, 0, "reset");
    chk(0, ALUOP, 0, "reset");
    chk(0, MRW, 0, "reset");
    chk(0, WRW, 0, "reset");
    chk(0, WDST, 0, "reset");
`ifdef FORWARDING_EN
    chk(0, FA, 0, "reset");
    chk(0, FB, 0, "reset");
`endif
    // ADDI $8,$0,5
    issue(6'h08, 6'h00, 0, 8, 0);
    chk(0, ILL, 0, "addi");
    chk(1, ALUOP, 4, "addi");
    chk(1, ALUSRC, 1, "addi");
    chk(1, REGDST, 0, "addi");
    chk(2, MRW, 1, "addi");
    chk(2, MDST, 8, "addi");
    chk(3, WRW, 1, "addi");
    chk(3, WDST, 8, "addi");
    chk(3, WLINK, 0, "addi");
    tick();
    nops(3);
    // LW $9,0($8) then ADD $10,$9,$9
    issue(6'h23, 6'h00, 8, 9, 0);
    chk(2, MRD, 1, "lw");
    chk(3, WMTR, 1, "lw");
    tick();
    issue(6'h00, 6'h20, 9, 9, 10);
    chk(0, PCW, 0, "loaduse");
    chk(0, IFW, 0, "loaduse");
    chk(1, ALUOP, 0, "loaduse bubble");
    chk(1, REGDST, 0, "loaduse bubble");
    tick();
`ifndef FORWARDING_EN
    chk(0, PCW, 0, "loaduse mem");
    chk(1, ALUOP, 0, "loaduse bubble2");
    tick();
`endif
    chk(0, PCW, 1, "loaduse release");
    chk(1, ALUOP, 7, "add ex");
    chk(1, EXRS, 9, "add ex");
`ifdef FORWARDING_EN
    chk(1, FA, 1, "fwd wb");
    chk(1, FB, 1, "fwd wb");
`endif
    tick();
    nops(3);
    // ADD $8,$1,$2 then SUB $11,$8,$8
    issue(6'h00, 6'h20, 1, 2, 8);
    tick();
    issue(6'h00, 6'h22, 8, 8, 11);
`ifndef FORWARDING_EN
    chk(0, PCW, 0, "raw ex");
    chk(0, IFW, 0, "raw ex");
    tick();
    chk(0, PCW, 0, "raw mem");
    tick();
`endif
    chk(0, PCW, 1, "raw release");
    chk(0, IFW, 1, "raw release");
    chk(1, ALUOP, 7, "sub ex");
`ifdef FORWARDING_EN
    chk(1, FA, 2, "fwd mem");
    chk(1, FB, 2, "fwd mem");
`endif
    tick();
    nops(3);
    // LW $12; BEQ $0,$0 taken in EX while ID holds ADD $13,$12,$12
    issue(6'h23, 6'h00, 0, 12, 0);
    tick();
    issue(6'h04, 6'h00, 0, 0, 0);
    chk(0, PCW, 1, "beq id");
    chk(1, BEQ, 1, "beq ex");
    chk(1, ALUOP, 0, "beq ex");
    tick();
    issue(6'h00, 6'h20, 12, 12, 13);
    bus.ex_branch_taken = 1'b1;
    chk(0, FLUSH, 1, "branch");
    chk(0, PCW, 1, "branch");
    chk(0, IFW, 1, "branch");
    chk(1, REGDST, 0, "branch bubble");
    chk(1, EXRS, 0, "branch bubble");
    tick();
    // J in ID while a branch resolves taken: jump suppressed
    issue(6'h02, 6'h00, 0, 0, 0);
    chk(0, JUMP, 0, "j vs branch");
    chk(0, FLUSH, 1, "j vs branch");
    tick();
    bus.ex_branch_taken = 1'b0;
    nops(3);
    // JAL then J
    issue(6'h03, 6'h00, 0, 0, 0);
    chk(0, JUMP, 1, "jal");
    chk(0, FLUSH, 1, "jal");
    chk(0, PCW, 1, "jal");
    chk(2, MRW, 1, "jal");
    chk(3, WLINK, 1, "jal");
    chk(3, WDST, 31, "jal");
    chk(3, WRW, 1, "jal");
    tick();
    issue(6'h02, 6'h00, 0, 0, 0);
    chk(0, JUMP, 1, "j");
    chk(3, WRW, 0, "j");
    chk(3, WDST, 0, "j");
    tick();
    nops(3);
    // Illegal opcode and the rest of the decode table
    issue(6'h3f, 6'h20, 3, 4, 5);
    chk(0, ILL, 1, "illegal");
    chk(0, JUMP, 0, "illegal");
    chk(1, ALUOP, 0, "illegal");
    chk(1, REGDST, 0, "illegal");
    chk(1, EXRS, 0, "illegal");
    chk(2, MRW, 0, "illegal");
    chk(3, WDST, 0, "illegal");
    tick();
    issue(6'h08, 6'h00, 3, 0, 0);
    chk(0, ILL, 0, "addi r0");
    chk(1, ALUOP, 4, "addi r0");
    chk(3, WRW, 0, "addi r0");
    tick();
    issue(6'h00, 6'h00, 0, 5, 6);
    chk(1, SHAMT, 1, "sll");
    chk(1, EXRT, 5, "sll");
    chk(3, WDST, 6, "sll");
    tick();
    issue(6'h0d, 6'h00, 1, 7, 0);
    chk(0, PCW, 1, "ori");
    chk(1, ALUOP, 5, "ori");
    chk(1, SHAMT, 0, "ori");
    tick();
    issue(6'h0f, 6'h00, 0, 9, 0);
    chk(1, ALUOP, 6, "lui");
    tick();
    issue(6'h2b, 6'h00, 1, 2, 0);
    chk(2, MWR, 1, "sw");
    chk(2, MRW, 0, "sw");
    tick();
    issue(6'h05, 6'h00, 0, 0, 0);
    chk(1, BNE, 1, "bne");
    chk(1, BEQ, 0, "bne");
    tick();
    nops(3);
    // Reset during a load-use stall
    issue(6'h23, 6'h00, 0, 9, 0);
    tick();
    issue(6'h00, 6'h20, 9, 9, 10);
    reset = 1'b1;
    chk(0, PCW, 1, "reset stall");
    chk(1, ALUOP, 0, "reset flush");
    chk(1, REGDST, 0, "reset flush");
    chk(1, EXRS, 0, "reset flush");
    chk(1, MRD, 0, "reset flush");
    chk(1, MRW, 0, "reset flush");
    chk(1, MDST, 0, "reset flush");
    chk(1, WRW, 0, "reset flush");
    chk(1, WDST, 0, "reset flush");
    tick();
    reset = 1'b0;
    chk(0, PCW, 1, "after reset");
    nops(4);
    nChecks++;
    if (sb.size() != 0) begin
      nFail++;
      $display("FAIL drain: got %0d pending, wanted 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
